// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake so the ALU controller can stall on it.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_n;

  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] quo_w;
  logic [WIDTH-1:0] dvs_w;
  logic [CNT_W-1:0] cnt_w;

  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic             last_iter;

  // One shift-and-subtract step. The shifted remainder needs WIDTH+1 bits;
  // the sign of the trial difference decides whether to keep or restore it.
  function automatic logic [2*WIDTH-1:0] restore_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic        [WIDTH:0]   shrem;
    logic signed [WIDTH:0]   trial;
    logic        [WIDTH-1:0] qs;
    shrem = {rem, quo[WIDTH-1]};
    qs    = quo << 1;
    trial = $signed(shrem) - $signed({1'b0, dvs});
    if (trial[WIDTH]) begin
      return {shrem[WIDTH-1:0], qs};
    end
    return {trial[WIDTH-1:0], qs | WIDTH'(1)};
  endfunction

  assign {rem_n, quo_n} = restore_step(rem_w, quo_w, dvs_w);
  assign last_iter      = (cnt_w == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = (divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Working registers advance only in RUN; the visible results change only on
  // completion (or the divide-by-zero shortcut) and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_w       <= '0;
      quo_w       <= '0;
      dvs_w       <= '0;
      cnt_w       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dvs_w <= divisor;
            rem_w <= '0;
            quo_w <= dividend;
            cnt_w <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_RUN: begin
          rem_w <= rem_n;
          quo_w <= quo_n;
          cnt_w <= cnt_w + CNT_W'(1);
          if (last_iter) begin
            quotient    <= quo_n;
            remainder   <= rem_n;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: table of divisions plus hand-written
// sequences for ignored starts, mid-operation reset and a checked sweep.
module tb_seq_divider;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int errors  = 0;
  int checks  = 0;
  int overlap = 0;

  always @(negedge clk) begin
    if (busy === 1'b1 && done === 1'b1) overlap++;
  end

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present operands for one cycle; returns at the first sample after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
  endtask

  // lat = index of the sample (1 = first after accept) where done is seen.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 1;
    nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done pulse, expected one within 40 cycles");
    end
  endtask

  vec_t vecs[14];
  int   lat;
  int   nb;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;

  initial begin
    vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vecs[3]  = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0};
    vecs[4]  = '{8'd200, 8'd0,   8'd255, 8'd200, 1'b1};
    vecs[5]  = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0};
    vecs[6]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[7]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    vecs[8]  = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
    vecs[9]  = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0};
    vecs[10] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
    vecs[11] = '{8'd1,   8'd0,   8'd255, 8'd1,   1'b1};
    vecs[12] = '{8'd81,  8'd9,   8'd9,   8'd0,   1'b0};
    vecs[13] = '{8'd200, 8'd13,  8'd15,  8'd5,   1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(lat, nb);
      chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].z);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].z ? 1 : WIDTH + 1);
      chk($sformatf("v%0d_busy_cycles", i), nb, vecs[i].z ? 0 : WIDTH);
      @(negedge clk);
      chk($sformatf("v%0d_done_falls", i), done, 0);
      chk($sformatf("v%0d_hold_quotient", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_hold_dbz", i), div_by_zero, vecs[i].z);
    end

    // start pulses in RUN and in DONE are ignored; restart right after done.
    issue(8'd100, 8'd7);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nb);
    chk("ign_done_at", lat, WIDTH - 2);
    chk("ign_quotient", quotient, 14);
    chk("ign_remainder", remainder, 2);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    chk("ign_done_no_restart", busy, 0);
    chk("ign_hold_quotient", quotient, 14);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", busy, 1);
    wait_done(lat, nb);
    chk("restart_quotient", quotient, 10);
    chk("restart_remainder", remainder, 0);

    // Asynchronous reset in the middle of a division clears everything at once.
    issue(8'd1, 8'd0);
    wait_done(lat, nb);
    chk("pre_rst_dbz", div_by_zero, 1);
    issue(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_idle", busy, 0);
    issue(8'd81, 8'd9);
    wait_done(lat, nb);
    chk("postrst_quotient", quotient, 9);
    chk("postrst_remainder", remainder, 0);
    chk("postrst_latency", lat, WIDTH + 1);

    // Operand sweep against the bench's own / and % (divisor 0 mixed in).
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom_range(0, 255));
      rb = (i % 16 == 0) ? '0 : WIDTH'($urandom_range(0, 255));
      issue(ra, rb);
      wait_done(lat, nb);
      if (rb == 0) begin
        chk($sformatf("rnd%0d_quotient(%0d/0)", i, ra), quotient, 255);
        chk($sformatf("rnd%0d_remainder(%0d/0)", i, ra), remainder, ra);
        chk($sformatf("rnd%0d_dbz", i), div_by_zero, 1);
      end else begin
        chk($sformatf("rnd%0d_quotient(%0d/%0d)", i, ra, rb), quotient, ra / rb);
        chk($sformatf("rnd%0d_remainder(%0d/%0d)", i, ra, rb), remainder, ra % rb);
        chk($sformatf("rnd%0d_dbz", i), div_by_zero, 0);
      end
    end

    chk("busy_done_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
